reg64_byte_unloader: RTL

- Reader end of the 64-bit register bank: captures a K-bit word from a bank's Q outputs on a load request.
- Streams the captured word out one byte per transfer over a valid/ready byte interface.
- Sits between the datapath register banks and a byte-wide consumer, such as a debug/UART bridge or a memory-write sequencer.
- Keeps a wrapping count of fully transmitted words.

---
 rtl/reg64_byte_unloader_if.sv | 10 +
 rtl/reg64_byte_unloader.sv | 92 +++++++++
 2 files changed

// File: rtl/reg64_byte_unloader_if.sv
// Byte-wide valid/ready stream carrying one captured word, least or most significant byte first.
interface reg64_byte_unloader_if;
    logic [7:0] dout;
    logic       dvalid;
    logic       dready;
    logic       last;

    modport master (output dout, output dvalid, output last, input dready);
    modport slave  (input dout, input dvalid, input last, output dready);
endinterface

// File: rtl/reg64_byte_unloader.sv
// Captures a K-bit register bank word on load and streams it out one byte per valid/ready
// transfer, counting fully transmitted words.
module reg64_byte_unloader #(
    parameter int unsigned K         = 64,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned CW        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [K-1:0]          d,
    input  logic                  load,
    input  logic                  abort,
    output logic                  ready,
    output logic [CW-1:0]         word_cnt,
    reg64_byte_unloader_if.master bus
);

    localparam int unsigned N  = K / 8;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e          state_q, state_d;
    logic [K-1:0]    shadow_q, shadow_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Byte lane depends only on registered index, so nothing here sees dready.
    always_comb begin
        sel = (MSB_FIRST != 0) ? (LastIdx - idx_q) : idx_q;
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ready      = 1'b0;
        bus.dvalid = 1'b0;
        bus.dout   = 8'h00;
        bus.last   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (load) begin
                    shadow_d = d;
                    idx_d    = '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                bus.dvalid = 1'b1;
                bus.dout   = shadow_q[{sel, 3'b000} +: 8];
                bus.last   = (idx_q == LastIdx);
                // Abort wins even over the final transfer, so a cancelled word is never counted.
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (bus.dready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign word_cnt = cnt_q;

endmodule
